// File: rtl/op2_imm_encoder_if.sv
// Request/result bundle for op2_imm_encoder.
//   master : requester side (drives start/value/cin, observes results)
//   slave  : encoder side
// Signals:
//   start  - request, sampled only while the encoder is idle
//   value  - 32-bit constant to encode, captured with start
//   cin    - incoming shifter carry, captured with start
//   busy   - search in progress
//   done   - one-cycle pulse, result valid
//   valid  - an encoding was found
//   enc    - {rot[3:0], imm8[7:0]}, zero when valid is low
//   cout   - shifter carry-out of the encoding
//   invert - encoding describes ~value (MVN form)
interface op2_imm_encoder_if;
  logic        start;
  logic [31:0] value;
  logic        cin;
  logic        busy;
  logic        done;
  logic        valid;
  logic [11:0] enc;
  logic        cout;
  logic        invert;

  modport master (
    output start, value, cin,
    input  busy, done, valid, enc, cout, invert
  );

  modport slave (
    input  start, value, cin,
    output busy, done, valid, enc, cout, invert
  );
endinterface

// File: rtl/op2_imm_encoder.sv
// Iterative encoder for the ARM data-processing rotated immediate.
// Searches rot = 0..15 for the smallest rot such that ROL(value, 2*rot) fits in
// 8 bits, returning enc = {rot, imm8} plus the carry-out the shifter's decode of
// that immediate would produce.
//
// Parameters:
//   CHECKS_PER_CYCLE - rotations tested per clock (1, 2, 4, 8 or 16)
// Ports:
//   i_clk   - clock, rising edge
//   i_rst_n - asynchronous active-low reset
//   bus     - op2_imm_encoder_if.slave request/result bundle
//
// Optional build macro OP2_IMM_ENCODER_NEG_SEARCH_EN: when the direct search
// fails, a second pass searches ~value and flags a hit with invert=1. Without
// it, invert is tied low and the second search state does not exist.
module op2_imm_encoder #(
  parameter int unsigned CHECKS_PER_CYCLE = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  op2_imm_encoder_if.slave         bus
);

  generate
    if (!(CHECKS_PER_CYCLE == 1 || CHECKS_PER_CYCLE == 2 || CHECKS_PER_CYCLE == 4 ||
          CHECKS_PER_CYCLE == 8 || CHECKS_PER_CYCLE == 16)) begin : g_bad_checks
      $error("op2_imm_encoder: CHECKS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_SEARCH   = 2'd1;
`ifdef OP2_IMM_ENCODER_NEG_SEARCH_EN
  localparam logic [1:0] ST_SEARCH_N = 2'd2;
`endif

  // Rotation base of the final group of checks.
  localparam logic [3:0] LAST_BASE = 4'(16 - CHECKS_PER_CYCLE);

  logic [1:0]  r_state;
  logic [3:0]  r_rot;
  logic [31:0] r_v;
  logic        r_c;
  logic        r_done;
  logic        r_valid;
  logic [11:0] r_enc;
  logic        r_cout;
`ifdef OP2_IMM_ENCODER_NEG_SEARCH_EN
  logic        r_invert;
`endif

  logic        w_hit;
  logic [3:0]  w_hit_rot;
  logic [7:0]  w_hit_imm;
  logic        w_last;

  function automatic logic [31:0] rol2(input logic [31:0] v, input logic [3:0] k);
    logic [63:0] t;
    t = {v, v} << {k, 1'b0};
    return t[63:32];
  endfunction

  // Scan the group from the top down so the lowest matching rotation is the
  // one left standing, keeping the encoding canonical.
  always_comb begin
    logic [3:0]  k;
    logic [31:0] rr;
    w_hit     = 1'b0;
    w_hit_rot = 4'd0;
    w_hit_imm = 8'd0;
    k         = 4'd0;
    rr        = 32'd0;
    for (int j = int'(CHECKS_PER_CYCLE) - 1; j >= 0; j--) begin
      k  = r_rot + 4'(j);
      rr = rol2(r_v, k);
      if (rr[31:8] == 24'd0) begin
        w_hit     = 1'b1;
        w_hit_rot = k;
        w_hit_imm = rr[7:0];
      end
    end
  end

  assign w_last = (r_rot == LAST_BASE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_IDLE;
      r_rot    <= 4'd0;
      r_v      <= 32'd0;
      r_c      <= 1'b0;
      r_done   <= 1'b0;
      r_valid  <= 1'b0;
      r_enc    <= 12'd0;
      r_cout   <= 1'b0;
`ifdef OP2_IMM_ENCODER_NEG_SEARCH_EN
      r_invert <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_v      <= bus.value;
            r_c      <= bus.cin;
            r_rot    <= 4'd0;
            r_state  <= ST_SEARCH;
            r_valid  <= 1'b0;
            r_enc    <= 12'd0;
            r_cout   <= 1'b0;
`ifdef OP2_IMM_ENCODER_NEG_SEARCH_EN
            r_invert <= 1'b0;
`endif
          end
        end
`ifdef OP2_IMM_ENCODER_NEG_SEARCH_EN
        ST_SEARCH, ST_SEARCH_N: begin
`else
        ST_SEARCH: begin
`endif
          if (w_hit) begin
            r_valid <= 1'b1;
            r_enc   <= {w_hit_rot, w_hit_imm};
            // Decoded value equals r_v, so for rot != 0 the carry is its MSB.
            r_cout  <= (w_hit_rot == 4'd0) ? r_c : r_v[31];
`ifdef OP2_IMM_ENCODER_NEG_SEARCH_EN
            r_invert <= (r_state == ST_SEARCH_N);
`endif
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end else if (w_last) begin
`ifdef OP2_IMM_ENCODER_NEG_SEARCH_EN
            if (r_state == ST_SEARCH) begin
              r_v     <= ~r_v;
              r_rot   <= 4'd0;
              r_state <= ST_SEARCH_N;
            end else begin
              r_valid  <= 1'b0;
              r_enc    <= 12'd0;
              r_cout   <= r_c;
              r_invert <= 1'b0;
              r_done   <= 1'b1;
              r_state  <= ST_IDLE;
            end
`else
            r_valid <= 1'b0;
            r_enc   <= 12'd0;
            r_cout  <= r_c;
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
`endif
          end else begin
            r_rot <= r_rot + 4'(CHECKS_PER_CYCLE);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy   = (r_state != ST_IDLE);
  assign bus.done   = r_done;
  assign bus.valid  = r_valid;
  assign bus.enc    = r_enc;
  assign bus.cout   = r_cout;
`ifdef OP2_IMM_ENCODER_NEG_SEARCH_EN
  assign bus.invert = r_invert;
`else
  assign bus.invert = 1'b0;
`endif

endmodule

// File: doc/op2_imm_encoder.md
Name: op2_imm_encoder

Overview:
Iterative encoder for the ARM data-processing rotated immediate (operand-2 bits [11:0] = rot[3:0], imm8[7:0]). It is the encode direction of the shifter unit's immediate decode, where value = ROR(imm8, 2*rot). Given a 32-bit constant, it searches the 16 rotations and returns the canonical encoding plus the shifter carry-out the decode side would produce. It sits beside the shifter unit and serves instruction generation and self-check logic.

Parameters:
CHECKS_PER_CYCLE, 1, rotations evaluated per clock; legal values 1, 2, 4, 8, 16; other values are a synthesis error.

Ports:
CLK  input  1  clock, rising edge
RST_N  input  1  asynchronous active-low reset
START  input  1  request; sampled only in IDLE
VALUE  input  32  constant to encode; captured with START
CIN  input  1  incoming carry; captured with START
BUSY  output  1  high while searching
DONE  output  1  one-cycle pulse when the result is valid
VALID  output  1  encoding found; meaningful while DONE=1
ENC  output  12  {rot[3:0], imm8[7:0]}; 0 when VALID=0
COUT  output  1  shifter carry-out of the encoding
INVERT  output  1  encoding applies to ~VALUE (MVN form)

Behaviour:
- Reset (async, RST_N=0): state IDLE. BUSY, DONE, VALID, ENC, COUT and INVERT all 0. The rotation counter clears. Reset mid-search aborts with no DONE.
- States are IDLE, SEARCH and (with the optional feature) SEARCH_N.
- IDLE: on an edge with START=1, capture VALUE into V and CIN into C, set r=0, go to SEARCH, BUSY=1.
- SEARCH: on each edge, test rotations r .. r+CHECKS_PER_CYCLE-1.
  - Match for rotation k: ROL(V, 2k)[31:8] == 0. Then imm8 = ROL(V, 2k)[7:0].
  - Lowest matching k wins, so the encoding is canonical (smallest rot).
  - On a match: register VALID=1, ENC={k, imm8}, DONE=1, BUSY=0, return to IDLE.
  - No match and the last rotation (15) tested: VALID=0, ENC=0, COUT=C, DONE=1, return to IDLE (or SEARCH_N, see below).
  - Otherwise: r += CHECKS_PER_CYCLE.
- Latency for CHECKS_PER_CYCLE=1: a match at rotation k gives DONE visible k+1 cycles after the START edge. A not-encodable value gives 16 cycles. Generally, DONE follows floor(k/CHECKS_PER_CYCLE)+1 cycles after the START edge.
- COUT: equals C when rot=0, otherwise bit 31 of the decoded value (ROR(imm8, 2*rot)).
- DONE is high for exactly one cycle. VALID, ENC, COUT and INVERT hold until the next accepted START, then clear to 0 on that edge.
- START while BUSY=1 is ignored, with no queuing.
- START in the cycle DONE=1 is accepted, since the block is already in IDLE. DONE then drops.
- VALUE and CIN changes after capture have no effect.
- VALUE=0 encodes as ENC=0x000 with COUT=C.

Optional Feature:
Macro: OP2_IMM_ENCODER_NEG_SEARCH_EN.
- With the macro: when the direct search fails, load V <= ~V, r=0, and enter SEARCH_N. SEARCH_N uses identical search rules.
  - On a match in SEARCH_N: VALID=1, INVERT=1, and ENC/COUT describe the encoding of ~VALUE.
  - Failure in SEARCH_N: VALID=0, INVERT=0.
  - Worst-case latency is 32 cycles at CHECKS_PER_CYCLE=1.
  - BUSY stays high across both passes.
- Without the macro: the INVERT port exists but is tied to 0, and the SEARCH_N state is not built.

Test Plan:
1. VALUE=0x00000050, CIN=0 -> DONE 1 cycle after START; VALID=1, ENC=0x050, COUT=0, INVERT=0.
2. VALUE=0xFF000000, CIN=0 -> DONE at cycle 5; ENC=0x4FF, COUT=1. VALUE=0xF000000F -> DONE at cycle 3; ENC=0x2FF, COUT=1.
3. VALUE=0x00000102 (odd rotation, not encodable) -> DONE at cycle 16; VALID=0, ENC=0, COUT=CIN. Repeat at CHECKS_PER_CYCLE=4 -> DONE at cycle 4.
4. START pulsed again at cycle 2 of a 0xFF000000 search -> ignored; single DONE at cycle 5 with ENC=0x4FF. Then START with VALUE=0x50 asserted in the DONE cycle -> accepted; DONE 1 cycle later with ENC=0x050.
5. RST_N low at cycle 3 of a 0x00000102 search -> all outputs 0 immediately; no DONE. After release, START with 0x50 -> normal result.
6. OP2_IMM_ENCODER_NEG_SEARCH_EN defined, VALUE=0xFFFFFFAF -> DONE at cycle 17; VALID=1, INVERT=1, ENC=0x050. Without the macro -> DONE at cycle 16; VALID=0, INVERT=0.
